// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg
//   Shared types for the core bus arbiter: the instruction and data bus
//   request/response structs, the single-beat memory channel structs, the
//   arbiter state encoding, and the helpers that format a master request
//   into a memory request.
package core_bus_arbiter_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [2:0]  msize_t;
  typedef logic [7:0]  strobe_t;

  // Access size encodes log2 of the byte count.
  localparam msize_t MSIZE1 = 3'b000;
  localparam msize_t MSIZE2 = 3'b001;
  localparam msize_t MSIZE4 = 3'b010;
  localparam msize_t MSIZE8 = 3'b011;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;   // all-zero strobe marks a read
    u64      data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef struct packed {
    logic    valid;
    logic    write;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    u64      data;
  } mem_req_t;

  typedef struct packed {
    logic ready;   // one-cycle completion pulse
    u64   data;
  } mem_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  // Instruction fetches are always 4-byte reads.
  function automatic mem_req_t ibus_to_mreq(input ibus_req_t req);
    mem_req_t m;
    m        = '0;
    m.valid  = 1'b1;
    m.write  = 1'b0;
    m.addr   = req.addr;
    m.size   = MSIZE4;
    m.strobe = '0;
    m.data   = '0;
    return m;
  endfunction

  function automatic mem_req_t dbus_to_mreq(input dbus_req_t req);
    mem_req_t m;
    m        = '0;
    m.valid  = 1'b1;
    m.write  = |req.strobe;
    m.addr   = req.addr;
    m.size   = req.size;
    m.strobe = req.strobe;
    m.data   = req.data;
    return m;
  endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Serialises the core's instruction-fetch bus and data bus onto a single
//   single-beat memory channel. One transaction is outstanding at a time;
//   ties are broken round-robin (data side wins the first tie after reset).
//   Responses come back as a registered one-cycle addr_ok/data_ok pulse to
//   the granted master only.
//
// Ports
//   clk    in   core clock
//   reset  in   synchronous, active-high reset
//   ireq   in   fetch request  (valid, addr)
//   iresp  out  fetch response (addr_ok, data_ok, 32-bit data)
//   dreq   in   data request   (valid, addr, size, strobe, data)
//   dresp  out  data response  (addr_ok, data_ok, 64-bit data)
//   mreq   out  memory request (valid, write, addr, size, strobe, data)
//   mresp  in   memory response (ready pulse, data)
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mem_req_t   mreq,
  input  mem_resp_t  mresp
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_d;
  logic       w_last_d_nxt;
  logic       r_abort;
  logic       w_abort_nxt;
  logic       r_grant_d;
  logic       w_grant_d_nxt;
  mem_req_t   r_req;
  mem_req_t   w_req_nxt;
  u64         r_rdata;
  u64         w_rdata_nxt;
  logic       w_grant_valid;
  logic       w_pick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_abort   <= 1'b0;
      r_grant_d <= 1'b0;
      r_req     <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_d  <= w_last_d_nxt;
      r_abort   <= w_abort_nxt;
      r_grant_d <= w_grant_d_nxt;
      r_req     <= w_req_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_d_nxt  = r_last_d;
    w_abort_nxt   = r_abort;
    w_grant_d_nxt = r_grant_d;
    w_req_nxt     = r_req;
    w_rdata_nxt   = r_rdata;
    w_grant_valid = r_grant_d ? dreq.valid : ireq.valid;
    // D wins when it is alone, or on a tie when I was granted last.
    w_pick_d      = dreq.valid && (!ireq.valid || !r_last_d);

    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d_nxt = 1'b1;
          w_last_d_nxt  = 1'b1;
          w_abort_nxt   = 1'b0;
          w_req_nxt     = dbus_to_mreq(dreq);
          w_state_nxt   = BUSY;
        end else if (ireq.valid) begin
          w_grant_d_nxt = 1'b0;
          w_last_d_nxt  = 1'b0;
          w_abort_nxt   = 1'b0;
          w_req_nxt     = ibus_to_mreq(ireq);
          w_state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (!w_grant_valid) begin
          w_abort_nxt = 1'b1;
        end
        if (mresp.ready) begin
          w_rdata_nxt = mresp.data;
          // A master that withdraws in the completion cycle itself is
          // treated as aborted too, so it never sees a stray response.
          if (r_abort || !w_grant_valid) begin
            w_abort_nxt = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      RESP: begin
        w_abort_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from state and registers only; nothing combinational
  // from the master or memory inputs reaches them.
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (r_state == BUSY) begin
      mreq = r_req;
    end
    if (r_state == RESP) begin
      if (r_grant_d) begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = r_rdata;
      end else begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = r_rdata[31:0];
      end
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter
//   Self-checking bench for core_bus_arbiter. Expected responses are queued
//   when a request is driven and compared by a monitor when a response
//   pulse appears; request formatting, hold, latency and quiet outputs are
//   checked from the stimulus sequence.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mem_req_t   mreq;
  mem_resp_t  mresp;

  core_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } resp_exp_t;

  resp_exp_t   exp_resp[$];
  resp_exp_t   mon_e;
  int unsigned resp_cyc[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned ready_cyc = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (iresp.addr_ok || iresp.data_ok || dresp.addr_ok || dresp.data_ok)) begin
      check("resp_expected", exp_resp.size() != 0, 1'b1);
      if (exp_resp.size() != 0) begin
        mon_e = exp_resp.pop_front();
        check("resp_d_ok", {dresp.addr_ok, dresp.data_ok}, {mon_e.is_d, mon_e.is_d});
        check("resp_i_ok", {iresp.addr_ok, iresp.data_ok}, {~mon_e.is_d, ~mon_e.is_d});
        check("resp_data", mon_e.is_d ? dresp.data : {32'h0, iresp.data}, mon_e.data);
        resp_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_req_t mk_req(input logic w, input logic [63:0] a, input logic [2:0] s,
                                      input logic [7:0] st, input logic [63:0] d);
    mem_req_t r;
    r.valid = 1'b1; r.write = w; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  // Wait (bounded) for the request, check it every BUSY cycle, then
  // complete it after wait_cyc extra cycles. Returns in the cycle after ready.
  task automatic serve(input mem_req_t exp_req, input int unsigned wait_cyc, input logic [63:0] rdata);
    int unsigned guard = 0;
    while (!mreq.valid && guard < 20) begin
      tick();
      guard++;
    end
    check("mreq_valid_wait", mreq.valid, 1'b1);
    for (int unsigned i = 0; i <= wait_cyc; i++) begin
      check("mreq_held", mreq, exp_req);
      if (i == wait_cyc) begin
        mresp.ready = 1'b1;
        mresp.data  = rdata;
        ready_cyc   = cyc;
      end
      tick();
    end
    mresp = '0;
  endtask

  mem_req_t    em_i, em_d;
  logic [63:0] rd;
  logic        is_d;

  initial begin
    reset = 1'b1; ireq = '0; dreq = '0; mresp = '0;
    tick(); tick();
    check("rst_mreq", mreq, '0);
    check("rst_iresp", iresp, '0);
    check("rst_dresp", dresp, '0);
    reset = 1'b0;

    // Contention: both valid continuously, ready on first BUSY cycle.
    ireq = '{valid: 1'b1, addr: 64'h8000_0100};
    dreq = '{valid: 1'b1, addr: 64'h8000_2000, size: 3'b011, strobe: 8'h00, data: 64'h0};
    em_i = mk_req(1'b0, 64'h8000_0100, 3'b010, 8'h00, 64'h0);
    em_d = mk_req(1'b0, 64'h8000_2000, 3'b011, 8'h00, 64'h0);
    for (int k = 0; k < 4; k++) begin
      is_d = (k % 2 == 0);
      rd   = 64'hA5A5_0000_C3C3_0000 + 64'(k);
      exp_resp.push_back('{is_d: is_d, data: is_d ? rd : (rd & 64'hFFFF_FFFF)});
      serve(is_d ? em_d : em_i, 0, rd);
    end
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    tick();
    check("cont_count", resp_cyc.size(), 4);
    for (int i = 0; i < 3; i++)
      if (resp_cyc.size() > i + 1) check("cont_spacing", resp_cyc[i+1] - resp_cyc[i], 3);

    // Single fetch, ready in the third BUSY cycle.
    ireq = '{valid: 1'b1, addr: 64'h8000_0000};
    exp_resp.push_back('{is_d: 1'b0, data: 64'h0000_0000_0010_0513});
    serve(mk_req(1'b0, 64'h8000_0000, 3'b010, 8'h00, 64'h0), 2, 64'h0000_0000_0010_0513);
    check("fetch_data_ok", iresp.data_ok, 1'b1);
    check("fetch_data", iresp.data, 32'h0010_0513);
    check("fetch_lat", cyc, ready_cyc + 1);
    check("fetch_dresp_quiet", dresp, '0);
    ireq.valid = 1'b0;
    tick();
    check("fetch_done_iresp", iresp, '0);
    check("fetch_done_mreq", mreq, '0);

    // Store.
    dreq = '{valid: 1'b1, addr: 64'h8000_1008, size: 3'b010, strobe: 8'hF0, data: 64'hDEAD_BEEF_0000_0000};
    exp_resp.push_back('{is_d: 1'b1, data: 64'h1122_3344_5566_7788});
    serve(mk_req(1'b1, 64'h8000_1008, 3'b010, 8'hF0, 64'hDEAD_BEEF_0000_0000), 1, 64'h1122_3344_5566_7788);
    check("store_data_ok", dresp.data_ok, 1'b1);
    check("store_lat", cyc, ready_cyc + 1);
    check("store_iresp_quiet", iresp, '0);
    dreq.valid = 1'b0;
    tick();

    // Stray ready while idle.
    mresp.ready = 1'b1; mresp.data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mresp = '0;
    check("stray_mreq", mreq, '0);
    check("stray_iresp", iresp, '0);
    check("stray_dresp", dresp, '0);
    tick();
    check("stray_mreq2", mreq, '0);
    check("stray_resp2", {iresp, dresp}, '0);

    // Abort: D granted, withdrawn in BUSY, ready two cycles later; I pending.
    dreq = '{valid: 1'b1, addr: 64'h8000_3000, size: 3'b011, strobe: 8'h00, data: 64'h0};
    em_d = mk_req(1'b0, 64'h8000_3000, 3'b011, 8'h00, 64'h0);
    em_i = mk_req(1'b0, 64'h8000_0200, 3'b010, 8'h00, 64'h0);
    tick();
    check("abort_grant_d", mreq, em_d);
    dreq.valid = 1'b0;
    ireq = '{valid: 1'b1, addr: 64'h8000_0200};
    exp_resp.push_back('{is_d: 1'b0, data: 64'h0000_0000_0BAD_F00D});
    tick();
    check("abort_hold", mreq, em_d);
    tick();
    mresp.ready = 1'b1; mresp.data = 64'h0123_4567_89AB_CDEF;
    tick();
    mresp = '0;
    check("abort_idle_mreq", mreq.valid, 1'b0);
    check("abort_no_dresp", dresp, '0);
    check("abort_no_iresp", iresp, '0);
    tick();
    check("abort_next_i", mreq, em_i);
    serve(em_i, 0, 64'hFEED_0000_0BAD_F00D);
    check("abort_i_data_ok", iresp.data_ok, 1'b1);
    ireq.valid = 1'b0;
    tick();

    // Reset mid-BUSY after a D grant; then a tie must still go to D.
    dreq = '{valid: 1'b1, addr: 64'h8000_4000, size: 3'b011, strobe: 8'h00, data: 64'h0};
    tick();
    check("rstmid_busy", mreq.valid, 1'b1);
    reset = 1'b1; dreq.valid = 1'b0;
    tick();
    reset = 1'b0;
    check("rstmid_mreq", mreq, '0);
    check("rstmid_resp", {iresp, dresp}, '0);
    mresp.ready = 1'b1; mresp.data = 64'h5555_AAAA_5555_AAAA;
    tick();
    mresp = '0;
    check("rstmid_ready_mreq", mreq, '0);
    tick();
    check("rstmid_ready_resp", {iresp, dresp}, '0);
    ireq = '{valid: 1'b1, addr: 64'h8000_0300};
    dreq = '{valid: 1'b1, addr: 64'h8000_5000, size: 3'b011, strobe: 8'h00, data: 64'h0};
    exp_resp.push_back('{is_d: 1'b1, data: 64'h7777_6666_5555_4444});
    serve(mk_req(1'b0, 64'h8000_5000, 3'b011, 8'h00, 64'h0), 0, 64'h7777_6666_5555_4444);
    check("rstmid_tie_d", dresp.data_ok, 1'b1);
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    tick(); tick(); tick();

    check("sb_drain", exp_resp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
